// File: rtl/set_condition_pipe_if.sv
// Beat-level bus for set_condition_pipe: request side (operands, condition)
// and result side (c, out_err), each with its own valid/ready handshake.
interface set_condition_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       code;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             out_err;

  modport master (
    output in_valid, a, b, code, is_signed, out_ready,
    input  in_ready, out_valid, c, out_err
  );

  modport slave (
    input  in_valid, a, b, code, is_signed, out_ready,
    output in_ready, out_valid, c, out_err
  );
endinterface

// File: rtl/set_condition_pipe.sv
// Two-stage compare pipeline: S1 captures operands, S2 evaluates the selected
// condition into a 0/1 result, with a saturating count of delivered true results.
module set_condition_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  set_condition_pipe_if.slave bus,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  true_count
);

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_code;
  logic             s1_signed;

  logic             out_valid_q;
  logic             c_q;
  logic             err_q;

  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic             lt;
  logic             eq;
  logic             cond;
  logic             illegal;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid = out_valid_q;
  assign bus.c         = {{(WIDTH-1){1'b0}}, c_q};
  assign bus.out_err   = err_q;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned magnitude comparator serves both modes.
  always_comb begin
    a_key   = s1_signed ? (s1_a ^ MSB_MASK) : s1_a;
    b_key   = s1_signed ? (s1_b ^ MSB_MASK) : s1_b;
    lt      = a_key < b_key;
    eq      = s1_a == s1_b;
    cond    = 1'b0;
    illegal = 1'b0;
    case (s1_code)
      3'b000:  cond = lt || eq;
      3'b001:  cond = lt;
      3'b010:  cond = !lt;
      3'b011:  cond = !lt && !eq;
      3'b100:  cond = eq;
      3'b101:  cond = !eq;
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_code   <= '0;
      s1_signed <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a      <= bus.a;
        s1_b      <= bus.b;
        s1_code   <= bus.code;
        s1_signed <= bus.is_signed;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      c_q         <= s1_valid && cond;
      err_q       <= s1_valid && illegal;
    end
  end

  // A clear in the same cycle as a counting transfer takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      true_count <= '0;
    end else if (clr_count) begin
      true_count <= '0;
    end else if (out_valid_q && bus.out_ready && c_q && (true_count != CNT_MAX)) begin
      true_count <= true_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/set_condition_pipe.md
SET_CONDITION_PIPE -- requirements
Module: set_condition_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width, legal range 2..64.
REQ-002 Parameter CNT_W, default 8: width of the true-result counter, legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 code  input  3  condition select: 000 A<=B, 001 A<B, 010 A>=B, 011 A>B, 100 A==B, 101 A!=B; 110 and 111 are illegal.
REQ-010 is_signed  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-011 clr_count  input  1  synchronous clear of true_count.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts a result beat.
REQ-014 c  output  WIDTH  result: 1 (zero-extended) if the condition holds, else 0.
REQ-015 out_err  output  1  the current result beat carried an illegal code.
REQ-016 true_count  output  CNT_W  count of accepted result beats with c==1.

Function
REQ-017 The block SHALL be a two-stage pipeline: S1 registers a, b, code and is_signed; S2 evaluates the condition and registers c and out_err.
REQ-018 A transfer SHALL occur on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready.
REQ-019 S2 SHALL advance when !out_valid||out_ready; S1 SHALL advance when !s1_valid||(S2 advances); in_ready SHALL equal the S1 advance condition.
REQ-020 Latency SHALL be 2 cycles from input transfer to out_valid with no stall; throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-021 While out_valid=1 and out_ready=0, c, out_err and out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-022 Comparison SHALL use all WIDTH bits, signed or unsigned according to the is_signed value captured with the same beat.
REQ-023 c[0] SHALL be the condition result and c[WIDTH-1:1] SHALL be 0 in every cycle.
REQ-024 For code 110/111, c SHALL be 0 and out_err SHALL be 1 for that beat; out_err SHALL be 0 for every legal code.
REQ-025 On each output transfer with c[0]=1, true_count SHALL increment by 1 and saturate at 2^CNT_W-1 (no wrap).
REQ-026 If clr_count=1 in the same cycle as a counting transfer, clr_count SHALL win and true_count SHALL become 0.
REQ-027 When S1 and S2 both hold beats and out_ready=0, in_ready SHALL be 0; when out_ready returns to 1, in_ready SHALL be 1 in that same cycle.

Reset
REQ-028 When rst=1, s1_valid, out_valid, c, out_err and true_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-029 A reset asserted mid-operation SHALL discard all in-flight beats; no beat accepted before reset SHALL appear after it.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 WIDTH=16, is_signed=0, a=0x0005, b=0x0005, codes 000..101 back-to-back, out_ready=1 -> c = 1,0,1,0,1,0 on six consecutive cycles, first result 2 cycles after the first input; true_count=3.
REQ-032 is_signed=1, a=0xFFFF, b=0x0001, code 001 -> c=1; same operands with is_signed=0 -> c=0.
REQ-033 Hold out_ready=0 and send 3 beats -> 2 beats accepted, in_ready=0, output held stable; release out_ready -> all 3 beats emerge in order with none lost.
REQ-034 code=111 -> c=0, out_err=1, true_count unchanged; next beat with code=100, a=b -> out_err=0, c=1.
REQ-035 CNT_W=2, 5 true beats -> true_count sequence 1,2,3,3,3; clr_count asserted together with a true transfer -> true_count=0.
REQ-036 Assert rst with 2 beats in flight -> out_valid=0 and true_count=0 asynchronously, and no stale beat after release.
